// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register feeding the ALU.
//
// Holds one decoded beat and drives the ALU operand and selector ports from
// registered state. The input and output sides each use a valid/ready
// handshake, and the stage sustains full throughput. A synchronous flush
// drops the held beat and discards the beat offered in the same cycle.
//
// Optional feature (macro ID_EX_WB_BYPASS_EN):
//   Defined:   a matching write-back result replaces the stored rs1/rs2
//              value, both at capture and while a beat is held. x0 never
//              matches.
//   Undefined: the wb_* ports are ignored. The register file must then
//              provide write-first reads.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   flush                   kill the held beat and this cycle's input beat
//   in_valid / in_ready     decode-side handshake
//   in_rs1_addr/in_rs2_addr source register indices
//   in_rs1_val/in_rs2_val   register-file reads
//   in_pc, in_imm           pc and sign-extended immediate
//   in_a_sel, in_b_sel      operand muxes (a: rs1/pc, b: rs2/imm)
//   in_alu_sel              ALU operation code
//   in_rd, in_reg_write     destination register and write enable
//   wb_we, wb_rd, wb_data   write-back port, used for bypass
//   out_valid / out_ready   EX-side handshake
//   alu_a, alu_b, alu_sel   ALU operands and selector
//   out_rd, out_reg_write   destination register and write enable, passed downstream
module id_ex_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_SEL = 4,
  parameter int unsigned REG_AW  = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_AW-1:0]  in_rs1_addr,
  input  logic [REG_AW-1:0]  in_rs2_addr,
  input  logic [WIDTH-1:0]   in_rs1_val,
  input  logic [WIDTH-1:0]   in_rs2_val,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic               in_a_sel,
  input  logic               in_b_sel,
  input  logic [ALU_SEL-1:0] in_alu_sel,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_reg_write,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [ALU_SEL-1:0] alu_sel,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_reg_write
);

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   rs1_val_q, rs1_val_d;
  logic [WIDTH-1:0]   rs2_val_q, rs2_val_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic               a_sel_q, a_sel_d;
  logic               b_sel_q, b_sel_d;
  logic [ALU_SEL-1:0] alu_sel_q, alu_sel_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic               reg_write_q, reg_write_d;
  logic               capture;

  // Independent of flush: a flushed input beat still completes its handshake.
  assign in_ready = ~valid_q | out_ready;
  assign capture  = in_valid & in_ready & ~flush;

`ifdef ID_EX_WB_BYPASS_EN
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic              wb_live;

  // x0 is hard-wired zero, so a write-back to it never forwards.
  assign wb_live = wb_we & (wb_rd != '0);

  always_comb begin
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    if (capture) begin
      rs1_addr_d = in_rs1_addr;
      rs2_addr_d = in_rs2_addr;
      rs1_val_d  = (wb_live && wb_rd == in_rs1_addr) ? wb_data : in_rs1_val;
      rs2_val_d  = (wb_live && wb_rd == in_rs2_addr) ? wb_data : in_rs2_val;
    end else if (valid_q && !flush) begin
      // Keep a held beat coherent with the register file as results retire.
      if (wb_live && wb_rd == rs1_addr_q) rs1_val_d = wb_data;
      if (wb_live && wb_rd == rs2_addr_q) rs2_val_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else begin
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wb_we, wb_rd, wb_data, in_rs1_addr, in_rs2_addr};

  always_comb begin
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    if (capture) begin
      rs1_val_d = in_rs1_val;
      rs2_val_d = in_rs2_val;
    end
  end
`endif

  always_comb begin
    pc_d        = pc_q;
    imm_d       = imm_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    alu_sel_d   = alu_sel_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    if (capture) begin
      pc_d        = in_pc;
      imm_d       = in_imm;
      a_sel_d     = in_a_sel;
      b_sel_d     = in_b_sel;
      alu_sel_d   = in_alu_sel;
      rd_d        = in_rd;
      reg_write_d = in_reg_write & (in_rd != '0);
    end
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q & ~out_ready;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      alu_sel_q   <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      alu_sel_q   <= alu_sel_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign out_valid     = valid_q;
  assign alu_a         = a_sel_q ? pc_q : rs1_val_q;
  assign alu_b         = b_sel_q ? imm_q : rs2_val_q;
  assign alu_sel       = alu_sel_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q;

endmodule
